// File: rtl/split_assign_loader_pkg.sv
// Shared constants, per-variable widths, mask helpers and loader state type.
package split_pkg;

    localparam int unsigned NUM_VARS = 50;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned IDX_W    = $clog2(NUM_VARS);
    localparam int unsigned VW_W     = $clog2(DATA_W + 1);

    // Declared bit width of each variable; beat k carries var_k.
    localparam int unsigned VAR_W [NUM_VARS] = '{
        5, 5, 7, 7, 5, 5, 6, 6, 7, 8,
        8, 4, 4, 4, 7, 8, 4, 6, 5, 8,
        8, 4, 7, 7, 8, 7, 6, 7, 8, 4,
        4, 8, 8, 7, 4, 5, 4, 5, 4, 7,
        4, 8, 8, 7, 4, 4, 8, 7, 8, 8
    };

    typedef enum logic {
        LOAD = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Low-order ones mask for a width of 0..DATA_W bits.
    function automatic logic [DATA_W-1:0] width_mask(input logic [VW_W-1:0] w);
        logic [DATA_W:0] one_hot;
        one_hot = (DATA_W + 1)'(1) << w;
        return DATA_W'(one_hot - 1'b1);
    endfunction

    function automatic logic [DATA_W-1:0] var_mask(input int unsigned k);
        return width_mask(VW_W'(VAR_W[k]));
    endfunction

endpackage

// File: rtl/split_assign_loader_if.sv
// Beat stream in, assembled frame out; master drives the upstream side.
interface split_assign_loader_if;
    import split_pkg::*;

    logic                       in_valid;
    logic                       in_ready;
    logic [DATA_W-1:0]          in_data;
    logic                       in_last;
    logic                       out_valid;
    logic                       out_ready;
    logic [NUM_VARS*DATA_W-1:0] out_data;
    logic                       out_err_range;
    logic                       out_err_frame;
    logic [CNT_W-1:0]           frame_cnt;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_err_range, out_err_frame, frame_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_err_range, out_err_frame, frame_cnt
    );

endinterface

// File: rtl/split_range_check.sv
// Masks a value to its declared width and flags any bits above it.
module split_range_check
    import split_pkg::*;
(
    input  logic [VW_W-1:0]   width_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              ovf_o
);

    logic [DATA_W-1:0] mask;

    // Keep the in-width bits, report anything outside them.
    always_comb begin
        mask   = width_mask(width_i);
        data_o = data_i & mask;
        ovf_o  = |(data_i & ~mask);
    end

endmodule

// File: rtl/split_assign_loader.sv
// Assembles NUM_VARS beats into one range-checked assignment frame and
// holds it for the evaluator until the output handshake.
module split_assign_loader
    import split_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    split_assign_loader_if.slave bus
);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [DATA_W-1:0] slots_q [NUM_VARS];
    logic [DATA_W-1:0] slots_d [NUM_VARS];
    logic              err_range_q, err_range_d;
    logic              err_frame_q, err_frame_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              in_ready_q, in_ready_d;

    logic [DATA_W-1:0] chk_data;
    logic              chk_ovf;
    logic              accept;
    logic              last_idx;

    split_range_check u_range_check (
        .width_i (VW_W'(VAR_W[k_q])),
        .data_i  (bus.in_data),
        .data_o  (chk_data),
        .ovf_o   (chk_ovf)
    );

    // in_ready is registered separately so it reads 0 while reset is held.
    assign accept   = bus.in_valid && in_ready_q;
    assign last_idx = (k_q == IDX_W'(NUM_VARS - 1));

    // Next-state: slot capture and termination in LOAD, release and clear in HOLD.
    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        slots_d     = slots_q;
        err_range_d = err_range_q;
        err_frame_d = err_frame_q;
        cnt_d       = cnt_q;
        case (state_q)
            LOAD: begin
                if (accept) begin
                    slots_d[k_q] = chk_data;
                    if (chk_ovf) begin
                        err_range_d = 1'b1;
                    end
                    k_d = k_q + IDX_W'(1);
                    if (bus.in_last || last_idx) begin
                        state_d = HOLD;
                    end
                    if (bus.in_last && !last_idx) begin
                        err_frame_d = 1'b1;
                        for (int unsigned j = 0; j < NUM_VARS; j++) begin
                            if (IDX_W'(j) > k_q) begin
                                slots_d[j] = '0;
                            end
                        end
                    end
                    if (!bus.in_last && last_idx) begin
                        err_frame_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    cnt_d       = cnt_q + CNT_W'(1);
                    slots_d     = '{default: '0};
                    err_range_d = 1'b0;
                    err_frame_d = 1'b0;
                    k_d         = '0;
                    state_d     = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
        in_ready_d = (state_d == LOAD);
    end

    // State register; reset discards any partial or held frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            k_q         <= '0;
            slots_q     <= '{default: '0};
            err_range_q <= 1'b0;
            err_frame_q <= 1'b0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            slots_q     <= slots_d;
            err_range_q <= err_range_d;
            err_frame_q <= err_frame_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
        end
    end

    // Flatten the slots onto the output bus.
    always_comb begin
        bus.out_data = '0;
        for (int unsigned j = 0; j < NUM_VARS; j++) begin
            bus.out_data[j*DATA_W +: DATA_W] = slots_q[j];
        end
    end

    assign bus.in_ready      = in_ready_q;
    assign bus.out_valid     = (state_q == HOLD);
    assign bus.out_err_range = err_range_q;
    assign bus.out_err_frame = err_frame_q;
    assign bus.frame_cnt     = cnt_q;

endmodule

// File: tb/tb_split_assign_loader.sv
// Directed bench for split_assign_loader with hand-computed expectations.
module tb_split_assign_loader;
    import split_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    split_assign_loader_if bus ();

    split_assign_loader dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [NUM_VARS*DATA_W-1:0] snapshot;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] slot(input int k);
        return 32'(bus.out_data[k*DATA_W +: DATA_W]);
    endfunction

    // Entered at a falling edge; returns at the falling edge after acceptance.
    task automatic send_beat(input logic [7:0] d, input logic l);
        int unsigned t = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = l;
        while (!bus.in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!bus.in_ready) chk("beat_timeout", 32'd0, 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Consumes the held frame and checks the post-handshake state.
    task automatic handshake(input logic [15:0] exp_cnt);
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk("hs_out_valid", 32'(bus.out_valid), 32'd0);
        chk("hs_in_ready", 32'(bus.in_ready), 32'd1);
        chk("hs_frame_cnt", 32'(bus.frame_cnt), 32'(exp_cnt));
        chk("hs_data_clear", 32'(|bus.out_data), 32'd0);
        chk("hs_flags_clear", 32'({bus.out_err_range, bus.out_err_frame}), 32'd0);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        // Reset values while held in reset.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_data", 32'(|bus.out_data), 32'd0);
        chk("rst_err_range", 32'(bus.out_err_range), 32'd0);
        chk("rst_err_frame", 32'(bus.out_err_frame), 32'd0);
        chk("rst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        // Clean frame: value k mod 16 fits every declared width.
        for (int k = 0; k < NUM_VARS; k++) begin
            send_beat(8'(k % 16), k == NUM_VARS - 1);
            if (k == NUM_VARS - 2) chk("clean_not_early", 32'(bus.out_valid), 32'd0);
        end
        chk("clean_out_valid", 32'(bus.out_valid), 32'd1);
        chk("clean_in_ready", 32'(bus.in_ready), 32'd0);
        for (int k = 0; k < NUM_VARS; k++)
            chk($sformatf("clean_slot%0d", k), slot(k), 32'(k % 16));
        chk("clean_err_range", 32'(bus.out_err_range), 32'd0);
        chk("clean_err_frame", 32'(bus.out_err_frame), 32'd0);
        chk("clean_cnt_before", 32'(bus.frame_cnt), 32'd0);
        handshake(16'd1);

        // Range violation on 4-bit variable 11.
        for (int k = 0; k < NUM_VARS; k++)
            send_beat((k == 11) ? 8'h1A : 8'(k % 16), k == NUM_VARS - 1);
        chk("range_out_valid", 32'(bus.out_valid), 32'd1);
        chk("range_slot11", slot(11), 32'h0A);
        chk("range_slot10", slot(10), 32'd10);
        chk("range_slot12", slot(12), 32'd12);
        chk("range_err_range", 32'(bus.out_err_range), 32'd1);
        chk("range_err_frame", 32'(bus.out_err_frame), 32'd0);
        handshake(16'd2);

        // Early end on beat 20; previous frame had nonzero slots above 20.
        for (int k = 0; k <= 20; k++) begin
            send_beat(8'(k % 16), k == 20);
            if (k == 19) chk("early_not_yet", 32'(bus.out_valid), 32'd0);
        end
        chk("early_out_valid", 32'(bus.out_valid), 32'd1);
        chk("early_slot20", slot(20), 32'd4);
        for (int k = 21; k < NUM_VARS; k++)
            chk($sformatf("early_zero%0d", k), slot(k), 32'd0);
        chk("early_err_frame", 32'(bus.out_err_frame), 32'd1);
        chk("early_err_range", 32'(bus.out_err_range), 32'd0);

        // Backpressure: pending beat waits while the frame is held.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'd3;
        bus.in_last  = 1'b0;
        snapshot = bus.out_data;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_stable", 32'(bus.out_data == snapshot), 32'd1);
        end
        handshake(16'd3);

        // Held beat becomes beat 0; frame then ends without in_last.
        send_beat(8'd3, 1'b0);
        for (int k = 1; k < NUM_VARS; k++) begin
            send_beat(8'(k % 16), 1'b0);
        end
        chk("miss_out_valid", 32'(bus.out_valid), 32'd1);
        chk("miss_err_frame", 32'(bus.out_err_frame), 32'd1);
        chk("miss_err_range", 32'(bus.out_err_range), 32'd0);
        chk("miss_slot0", slot(0), 32'd3);
        chk("miss_slot1", slot(1), 32'd1);
        chk("miss_slot49", slot(49), 32'd1);
        chk("miss_cnt_before", 32'(bus.frame_cnt), 32'd3);
        handshake(16'd4);

        // Mid-frame reset after beat 30.
        for (int k = 0; k <= 30; k++) send_beat(8'h0F, 1'b0);
        chk("mid_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_cnt", 32'(bus.frame_cnt), 32'd4);
        #1 rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_frame_cnt", 32'(bus.frame_cnt), 32'd0);
        chk("mrst_out_data", 32'(|bus.out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mrel_in_ready", 32'(bus.in_ready), 32'd1);

        // New frame with out_ready held high: one cycle in HOLD.
        bus.out_ready = 1'b1;
        for (int k = 0; k < NUM_VARS; k++)
            send_beat(8'(k % 8), k == NUM_VARS - 1);
        chk("post_out_valid", 32'(bus.out_valid), 32'd1);
        for (int k = 0; k < NUM_VARS; k++)
            chk($sformatf("post_slot%0d", k), slot(k), 32'(k % 8));
        chk("post_flags", 32'({bus.out_err_range, bus.out_err_frame}), 32'd0);
        chk("post_cnt_before", 32'(bus.frame_cnt), 32'd0);
        @(negedge clk);
        chk("post_one_hold", 32'(bus.out_valid), 32'd0);
        chk("post_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_cnt", 32'(bus.frame_cnt), 32'd1);
        bus.out_ready = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
